// File: rtl/led_drv_pkg.sv
// Shared definitions for the LED-driver latch protocol (matrix shifter and receiver).
// Latch layout: bit 768 = select, 767:0 = payload; control frames carry an 8-bit header at 767:760.
package led_drv_pkg;

  localparam int unsigned LATCH_SIZE  = 769;
  localparam int unsigned GS_WIDTH    = 16;
  localparam int unsigned CHANNELS    = 16;
  localparam int unsigned DC_WIDTH    = 7;
  localparam int unsigned COUNT_WIDTH = 11;

  localparam logic [7:0]  CTRL_HEADER = 8'h96;
  localparam int unsigned HDR_LSB     = 760;

  localparam int unsigned DC_LSB  = 0;
  localparam int unsigned MC_LSB  = 336;
  localparam int unsigned BC_LSB  = 345;
  localparam int unsigned FC_LSB  = 366;
  localparam int unsigned DC_BITS = 336;
  localparam int unsigned MC_BITS = 9;
  localparam int unsigned BC_BITS = 21;
  localparam int unsigned FC_BITS = 5;

  typedef struct packed {
    logic [MC_BITS-1:0] mc;
    logic [BC_BITS-1:0] bc;
    logic [FC_BITS-1:0] fc;
  } ctrl_fields_t;

  typedef enum logic [1:0] {
    FRAME_LEN_ERR,
    FRAME_CTRL,
    FRAME_HDR_ERR,
    FRAME_GS
  } frame_kind_t;

  // Classification of a completed latch, from its select bit, header byte and bit count.
  function automatic frame_kind_t classify(input logic                   sel,
                                           input logic [7:0]             header,
                                           input logic [COUNT_WIDTH-1:0] count);
    if (count != COUNT_WIDTH'(LATCH_SIZE)) return FRAME_LEN_ERR;
    if (sel && header == CTRL_HEADER)      return FRAME_CTRL;
    if (sel)                               return FRAME_HDR_ERR;
    return FRAME_GS;
  endfunction

endpackage

// File: rtl/led_rx_edge_sync.sv
// Input conditioning plus rising-edge detect for one receiver pin.
// LED_DRIVER_RX_SYNC_EN selects a 2-flop synchronizer; otherwise a single register stage.
module led_rx_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise
);

  logic prev;

`ifdef LED_DRIVER_RX_SYNC_EN
  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta  <= 1'b0;
      level <= 1'b0;
    end else begin
      meta  <= din;
      level <= meta;
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) level <= 1'b0;
    else        level <= din;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev <= 1'b0;
    else        prev <= level;
  end

  assign rise = level & ~prev;

endmodule

// File: rtl/led_driver_rx.sv
// Driver-side receiver for the LED latch protocol: shifts SIN on SCLK, decodes the latch on LAT.
// Build option LED_DRIVER_RX_SYNC_EN adds a 2-flop synchronizer on every input pin.
module led_driver_rx #(
  parameter int unsigned LATCH_SIZE = 769,
  parameter int unsigned GS_WIDTH   = 16,
  parameter int unsigned CHANNELS   = 16
) (
  input  logic                             CLK,
  input  logic                             nReset,
  input  logic                             SIN,
  input  logic                             SCLK,
  input  logic                             LAT,
  output logic                             SOUT,
  output logic [CHANNELS*3*GS_WIDTH-1:0]   gs_data,
  output logic [CHANNELS*3*7-1:0]          dc_data,
  output logic [8:0]                       mc,
  output logic [20:0]                      bc,
  output logic [4:0]                       fc,
  output logic                             gs_update,
  output logic                             ctrl_update,
  output logic                             hdr_err,
  output logic                             len_err,
  output logic [10:0]                      bit_count
);

  import led_drv_pkg::*;

  logic                  sin_c;
  logic                  sin_rise_unused;
  logic                  sclk_level_unused;
  logic                  sclk_rise;
  logic                  lat_level_unused;
  logic                  lat_rise;
  logic [LATCH_SIZE-1:0] shift_reg;
  ctrl_fields_t          ctrl_q;
  frame_kind_t           frame_kind;

  led_rx_edge_sync u_sin (
    .clk   (CLK),
    .rst_n (nReset),
    .din   (SIN),
    .level (sin_c),
    .rise  (sin_rise_unused)
  );

  led_rx_edge_sync u_sclk (
    .clk   (CLK),
    .rst_n (nReset),
    .din   (SCLK),
    .level (sclk_level_unused),
    .rise  (sclk_rise)
  );

  led_rx_edge_sync u_lat (
    .clk   (CLK),
    .rst_n (nReset),
    .din   (LAT),
    .level (lat_level_unused),
    .rise  (lat_rise)
  );

  assign frame_kind = classify(shift_reg[LATCH_SIZE-1], shift_reg[HDR_LSB +: 8], bit_count);

  // Decode reads shift_reg before the shift below takes effect, so a coincident
  // SCLK edge contributes bit 1 of the following frame.
  always_ff @(posedge CLK or negedge nReset) begin
    if (!nReset) begin
      shift_reg   <= '0;
      bit_count   <= '0;
      gs_data     <= '0;
      dc_data     <= '0;
      ctrl_q      <= '0;
      gs_update   <= 1'b0;
      ctrl_update <= 1'b0;
      hdr_err     <= 1'b0;
      len_err     <= 1'b0;
    end else begin
      gs_update   <= 1'b0;
      ctrl_update <= 1'b0;
      hdr_err     <= 1'b0;
      len_err     <= 1'b0;

      if (lat_rise) begin
        unique case (frame_kind)
          FRAME_LEN_ERR: len_err <= 1'b1;
          FRAME_HDR_ERR: hdr_err <= 1'b1;
          FRAME_CTRL: begin
            dc_data     <= shift_reg[DC_LSB +: DC_BITS];
            ctrl_q      <= '{mc: shift_reg[MC_LSB +: MC_BITS],
                             bc: shift_reg[BC_LSB +: BC_BITS],
                             fc: shift_reg[FC_LSB +: FC_BITS]};
            ctrl_update <= 1'b1;
          end
          FRAME_GS: begin
            gs_data   <= shift_reg[LATCH_SIZE-2:0];
            gs_update <= 1'b1;
          end
          default: ;
        endcase
      end

      if (sclk_rise) shift_reg <= {shift_reg[LATCH_SIZE-2:0], sin_c};

      if (lat_rise)                      bit_count <= sclk_rise ? 11'd1 : '0;
      else if (sclk_rise && bit_count != '1) bit_count <= bit_count + 11'd1;
    end
  end

  assign SOUT = shift_reg[LATCH_SIZE-1];
  assign mc   = ctrl_q.mc;
  assign bc   = ctrl_q.bc;
  assign fc   = ctrl_q.fc;

endmodule

// File: tb/tb_led_driver_rx.sv
// Self-checking bench for led_driver_rx: random frames against a bit-stream reference model.
module tb_led_driver_rx;

  logic         CLK = 1'b0;
  logic         nReset = 1'b0;
  logic         SIN = 1'b0;
  logic         SCLK = 1'b0;
  logic         LAT = 1'b0;
  logic         SOUT;
  logic [767:0] gs_data;
  logic [335:0] dc_data;
  logic [8:0]   mc;
  logic [20:0]  bc;
  logic [4:0]   fc;
  logic         gs_update, ctrl_update, hdr_err, len_err;
  logic [10:0]  bit_count;

  led_driver_rx #(.LATCH_SIZE(769), .GS_WIDTH(16), .CHANNELS(16)) dut (
    .CLK(CLK), .nReset(nReset), .SIN(SIN), .SCLK(SCLK), .LAT(LAT), .SOUT(SOUT),
    .gs_data(gs_data), .dc_data(dc_data), .mc(mc), .bc(bc), .fc(fc),
    .gs_update(gs_update), .ctrl_update(ctrl_update), .hdr_err(hdr_err),
    .len_err(len_err), .bit_count(bit_count)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int passed = 0;

  // Pulse counters, sampled once per cycle away from the active edge.
  int n_gs = 0, n_ctrl = 0, n_hdr = 0, n_len = 0;
  always @(negedge CLK) begin
    if (gs_update)   n_gs++;
    if (ctrl_update) n_ctrl++;
    if (hdr_err)     n_hdr++;
    if (len_err)     n_len++;
  end

  // Reference model: every bit shifted since reset; the latch is the newest 769 of them.
  bit           stream[$];
  int           m_count = 0;
  logic [767:0] m_gs = '0;
  logic [335:0] m_dc = '0;
  logic [8:0]   m_mc = '0;
  logic [20:0]  m_bc = '0;
  logic [4:0]   m_fc = '0;

  function automatic logic [768:0] model_latch();
    logic [768:0] v = '0;
    for (int i = 0; i < 769; i++) begin
      int idx = stream.size() - 1 - i;
      if (idx >= 0) v[i] = stream[idx];
    end
    return v;
  endfunction

  function automatic logic [768:0] rand_frame();
    logic [768:0] v;
    for (int i = 0; i < 769; i++) v[i] = 1'($urandom_range(0, 1));
    return v;
  endfunction

  function automatic void model_push(input bit b);
    stream.push_back(b);
    if (stream.size() > 769) stream.delete(0);
    if (m_count < 2047) m_count++;
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic send_bit(input bit b, input bit chk_sout);
    logic [768:0] lat_v;
    logic         exp_sout;
    SIN  = b;
    SCLK = 1'b0;
    cycles(3);
    SCLK = 1'b1;
    cycles(3);
    model_push(b);
    if (chk_sout) begin
      lat_v    = model_latch();
      exp_sout = lat_v[768];
      checks++;
      if (SOUT !== exp_sout) $display("FAIL sout after %0d bits: got %b want %b", m_count, SOUT, exp_sout);
      else passed++;
    end
  endtask

  task automatic send_frame(input logic [768:0] f, input bit chk_sout);
    for (int i = 768; i >= 0; i--) send_bit(f[i], chk_sout);
  endtask

  // Strobe LAT (optionally together with an SCLK rise carrying bit b) and verify the decode.
  task automatic pulse_lat(input string tag, input bit with_sclk, input bit b);
    logic [768:0] lat_v;
    int e_gs = 0, e_ctrl = 0, e_hdr = 0, e_len = 0;
    lat_v = model_latch();
    if (m_count != 769) e_len = 1;
    else if (lat_v[768] && lat_v[767:760] == 8'h96) begin
      e_ctrl = 1;
      m_dc = lat_v[335:0];
      m_mc = lat_v[344:336];
      m_bc = lat_v[365:345];
      m_fc = lat_v[370:366];
    end else if (lat_v[768]) e_hdr = 1;
    else begin
      e_gs = 1;
      m_gs = lat_v[767:0];
    end

    n_gs = 0; n_ctrl = 0; n_hdr = 0; n_len = 0;
    if (with_sclk) begin
      SIN  = b;
      SCLK = 1'b0;
      cycles(3);
      SCLK = 1'b1;
    end
    LAT = 1'b1;
    cycles(3);
    LAT  = 1'b0;
    SCLK = 1'b0;
    cycles(4);
    m_count = 0;
    if (with_sclk) model_push(b);

    checks++; if (n_gs !== e_gs)     $display("FAIL %s gs_update count: got %0d want %0d", tag, n_gs, e_gs); else passed++;
    checks++; if (n_ctrl !== e_ctrl) $display("FAIL %s ctrl_update count: got %0d want %0d", tag, n_ctrl, e_ctrl); else passed++;
    checks++; if (n_hdr !== e_hdr)   $display("FAIL %s hdr_err count: got %0d want %0d", tag, n_hdr, e_hdr); else passed++;
    checks++; if (n_len !== e_len)   $display("FAIL %s len_err count: got %0d want %0d", tag, n_len, e_len); else passed++;
    checks++; if (gs_data !== m_gs)  $display("FAIL %s gs_data: got %h want %h", tag, gs_data, m_gs); else passed++;
    checks++; if (dc_data !== m_dc)  $display("FAIL %s dc_data: got %h want %h", tag, dc_data, m_dc); else passed++;
    checks++; if (mc !== m_mc)       $display("FAIL %s mc: got %h want %h", tag, mc, m_mc); else passed++;
    checks++; if (bc !== m_bc)       $display("FAIL %s bc: got %h want %h", tag, bc, m_bc); else passed++;
    checks++; if (fc !== m_fc)       $display("FAIL %s fc: got %b want %b", tag, fc, m_fc); else passed++;
    checks++; if (bit_count !== 11'(m_count)) $display("FAIL %s bit_count: got %0d want %0d", tag, bit_count, m_count); else passed++;
  endtask

  task automatic test_reset();
    nReset = 1'b0;
    cycles(3);
    checks++; if (SOUT !== 1'b0)      $display("FAIL reset sout: got %b want 0", SOUT); else passed++;
    checks++; if (gs_data !== '0)     $display("FAIL reset gs_data: got %h want 0", gs_data); else passed++;
    checks++; if ({dc_data, mc, bc, fc} !== '0) $display("FAIL reset ctrl fields: got %h want 0", {dc_data, mc, bc, fc}); else passed++;
    checks++; if ({gs_update, ctrl_update, hdr_err, len_err} !== 4'b0)
      $display("FAIL reset pulses: got %b want 0000", {gs_update, ctrl_update, hdr_err, len_err}); else passed++;
    checks++; if (bit_count !== 11'd0) $display("FAIL reset bit_count: got %0d want 0", bit_count); else passed++;
    nReset = 1'b1;
    cycles(3);
  endtask

  task automatic test_control_frame();
    logic [768:0] f = rand_frame();
    f[768]     = 1'b1;
    f[767:760] = 8'h96;
    f[335:0]   = '1;
    f[344:336] = '0;
    f[365:345] = '1;
    f[370:366] = 5'b11011;
    send_frame(f, 1'b0);
    pulse_lat("ctrl", 1'b0, 1'b0);
    checks++; if (dc_data !== {48{7'd127}}) $display("FAIL ctrl dc all-127: got %h want all ones", dc_data); else passed++;
    checks++; if (bc !== 21'h1FFFFF) $display("FAIL ctrl bc: got %h want 1fffff", bc); else passed++;
    checks++; if (gs_data !== '0)    $display("FAIL ctrl gs untouched: got %h want 0", gs_data); else passed++;
  endtask

  task automatic test_gs_frame();
    logic [768:0] f = '0;
    for (int c = 0; c < 16; c++) f[(3*c)*16 +: 16] = 16'h8001;
    send_frame(f, 1'b0);
    pulse_lat("gs", 1'b0, 1'b0);
    checks++; if (gs_data[15:0] !== 16'h8001)  $display("FAIL gs ch0 red: got %h want 8001", gs_data[15:0]); else passed++;
    checks++; if (gs_data[31:16] !== 16'h0)    $display("FAIL gs ch0 green: got %h want 0000", gs_data[31:16]); else passed++;
    checks++; if (gs_data[63:48] !== 16'h8001) $display("FAIL gs ch1 red: got %h want 8001", gs_data[63:48]); else passed++;
  endtask

  task automatic test_hdr_err();
    logic [768:0] f = rand_frame();
    f[768]     = 1'b1;
    f[767:760] = 8'h95;
    send_frame(f, 1'b0);
    pulse_lat("hdr", 1'b0, 1'b0);
    checks++; if (fc !== 5'b11011) $display("FAIL hdr fc kept: got %b want 11011", fc); else passed++;
  endtask

  task automatic test_short_frame();
    logic [768:0] f = rand_frame();
    for (int i = 767; i >= 0; i--) send_bit(f[i], 1'b0);
    pulse_lat("short", 1'b0, 1'b0);
  endtask

  task automatic test_chain();
    logic [768:0] a = rand_frame();
    logic [768:0] b = rand_frame();
    b[768] = 1'b0;
    send_frame(a, 1'b0);
    send_frame(b, 1'b1);
    pulse_lat("chain", 1'b0, 1'b0);
  endtask

  task automatic test_random_gs();
    logic [768:0] f = rand_frame();
    f[768] = 1'b0;
    send_frame(f, 1'b0);
    pulse_lat("rand_gs", 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [768:0] f = rand_frame();
    logic [768:0] g = rand_frame();
    f[768] = 1'b0;
    g[768] = 1'b0;
    send_frame(f, 1'b0);
    pulse_lat("same_cycle", 1'b1, g[768]);
    for (int i = 767; i >= 0; i--) send_bit(g[i], 1'b0);
    pulse_lat("after_same_cycle", 1'b0, 1'b0);
  endtask

  task automatic test_async_reset();
    logic [768:0] f = rand_frame();
    for (int i = 0; i < 400; i++) send_bit(f[i], 1'b0);
    nReset = 1'b0;
    SCLK   = 1'b0;
    #1;
    checks++; if ({SOUT, gs_data, dc_data, mc, bc, fc} !== '0)
      $display("FAIL async reset data: got nonzero want 0"); else passed++;
    checks++; if ({gs_update, ctrl_update, hdr_err, len_err, bit_count} !== '0)
      $display("FAIL async reset status: got %h want 0", {gs_update, ctrl_update, hdr_err, len_err, bit_count}); else passed++;
    stream.delete();
    m_count = 0;
    m_gs = '0; m_dc = '0; m_mc = '0; m_bc = '0; m_fc = '0;
    cycles(3);
    nReset = 1'b1;
    cycles(3);
    f = rand_frame();
    f[768] = 1'b0;
    send_frame(f, 1'b0);
    pulse_lat("post_reset_gs", 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_control_frame();
    test_gs_frame();
    test_hdr_err();
    test_short_frame();
    test_chain();
    test_random_gs();
    test_back_to_back();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
